pkt_bundled_tx: RTL
===================

Name: pkt_bundled_tx

Overview:
- Clocked packet transmitter that drives the 2-phase bundled-data (req/ack) channel into the asynchronous pipeline under test.
- Generates numbered multi-word packets and flags the tail word in Data[1], so the downstream packet receiver counts one packet per tail.
- Synchronises the returning ack, enforces data-before-req setup and watches for a stalled ack.

Parameters:
- WORD_WIDTH, 32, data word width (must be >= 16).
- SETUP_CYCLES, 2, clock cycles Data is held stable before req toggles (bundling margin, >= 1).
- GAP_CYCLES, 4, idle cycles between packets (0 allowed).
- SYNC_STAGES, 2, flip-flop stages on the ack synchroniser (>= 2).
- TIMEOUT, 1024, cycles allowed in WAIT_ACK before timeout_err is set.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; launches a burst when idle or done.
- num_packets  in  16  packets in the burst; latched on start.
- pkt_len  in  6  words per packet; latched on start; 0 is treated as 1.
- req  out  1  2-phase request; every toggle offers one word.
- ack  in  1  2-phase acknowledge from the async pipeline; asynchronous to clk.
- Data  out  WORD_WIDTH  bundled data word.
- PacketTX  out  16  count of packets whose tail word has been acknowledged.
- busy  out  1  high from LOAD through GAP.
- Finished  out  1  burst complete; held until the next start.
- timeout_err  out  1  sticky; ack did not arrive within TIMEOUT cycles.

Behaviour:
- Reset (asynchronous, any state, including mid-packet):
  - req=0, Data=0, PacketTX=0, busy=0, Finished=0, timeout_err=0.
  - Synchroniser flops and all counters cleared; state=IDLE.
  - The receiver must be reset together with this block, because channel phase restarts at req=ack=0.
- ack path: passes through SYNC_STAGES flops to give ack_s. A transfer is complete when ack_s==req.
- Data word format:
  - bit0 = head (word index 0).
  - bit1 = tail (word index pkt_len-1).
  - [7:2] = word index.
  - [WORD_WIDTH-1:8] = packet index, truncated.
  - A single-word packet has both head and tail set (bits[1:0]=2'b11).
- IDLE:
  - start=1 latches num_packets and pkt_len, clears PacketTX, goes to LOAD.
  - If num_packets==0, go straight to DONE instead: no req toggle; Finished=1 on the next cycle.
- LOAD (1 cycle): register Data for the current packet/word; go to SETUP.
- SETUP:
  - Hold Data for SETUP_CYCLES cycles, then toggle req on exit to WAIT_ACK.
  - A req edge therefore always follows the last Data change by >= SETUP_CYCLES+1 cycles.
- WAIT_ACK:
  - Data and req are frozen.
  - On ack_s==req:
    - Non-tail word: word index +1, go to LOAD.
    - Tail word: PacketTX +1 in the same cycle. If this was the last packet, go to DONE; else packet index +1, word index 0, go to GAP (or to LOAD when GAP_CYCLES==0).
- Timeout:
  - A cycle counter runs in WAIT_ACK and clears on every entry to the state.
  - Reaching TIMEOUT sets timeout_err (sticky until reset).
  - State stays WAIT_ACK; a late ack still completes the transfer normally.
- GAP: count GAP_CYCLES cycles, then go to LOAD.
- DONE:
  - Finished=1, busy=0.
  - start restarts the burst: Finished clears the next cycle and PacketTX clears.
  - req keeps its current phase; there is no return-to-zero.
- Ignored inputs:
  - start while busy is ignored.
  - An ack edge outside WAIT_ACK is ignored, but keeps tracking via ack_s. A spurious edge makes ack_s!=req and stalls the next transfer until it is resolved.
- Counters: PacketTX wraps 16'hFFFF->0. Packet index and word index counters have no overflow flag.

Test Plan:
- Basic burst: num_packets=3, pkt_len=4, ack=req delayed 1 ns.
  - 12 req toggles, PacketTX=3, then Finished=1.
  - Word sequence 1,4,8,14,257,260,264,270,513,516,520,526.
- Single-word packets: num_packets=2, pkt_len=1 (and separately pkt_len=0).
  - Data=3 then 259; PacketTX=2.
- Setup check: SETUP_CYCLES=3, random ack delays of 0–50 clocks.
  - Assertion: Data is unchanged during the >= 4 cycles before every req edge.
  - No req toggle while ack_s!=req.
- Timeout: TIMEOUT=16, ack held constant after the first word.
  - timeout_err=1 exactly 16 cycles after entry to WAIT_ACK.
  - Releasing ack then completes the burst; timeout_err stays 1.
- Reset mid-packet: reset asserted during word 2 of packet 1.
  - req=0, Data=0, PacketTX=0, busy=0 immediately (asynchronously).
  - A new start after reset produces word 1 with req going 0->1.
- Zero/restart: num_packets=0 gives Finished=1 one cycle after start with no req edge. Then start with num_packets=1, pkt_len=2 gives PacketTX=1.

Source files
------------

// File: rtl/pkt_bundled_tx.sv
// Clocked 2-phase bundled-data packet source: numbered multi-word packets, tail flagged in Data[1].
// Latency: start -> first req toggle = 1 (LOAD) + SETUP_CYCLES cycles; ack seen SYNC_STAGES cycles after it lands.
// Backpressure: one word in flight; waits in WAIT_ACK until synchronised ack matches req, flags a stall after TIMEOUT.
module pkt_bundled_tx #(
    parameter int WORD_WIDTH   = 32,
    parameter int SETUP_CYCLES = 2,
    parameter int GAP_CYCLES   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           num_packets,
    input  logic [5:0]            pkt_len,
    output logic                  req,
    input  logic                  ack,
    output logic [WORD_WIDTH-1:0] Data,
    output logic [15:0]           PacketTX,
    output logic                  busy,
    output logic                  Finished,
    output logic                  timeout_err
);

    localparam int PW = WORD_WIDTH - 8;
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [PW-1:0] pkt;
        logic [5:0]    wrd;
        logic          tail;
        logic          head;
    } word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        WAIT_ACK,
        GAP,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    word_t                  data_q, data_d;
    logic [15:0]            pkt_tx_q, pkt_tx_d;
    logic                   fin_q, fin_d;
    logic                   to_err_q, to_err_d;
    logic [15:0]            num_q, num_d;
    logic [5:0]             len_q, len_d;
    logic [15:0]            pkt_idx_q, pkt_idx_d;
    logic [5:0]             word_idx_q, word_idx_d;
    logic [SW-1:0]          setup_cnt_q, setup_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;
    logic                   is_tail;
    logic                   is_last_pkt;
    logic                   xfer_done;

    function automatic word_t make_word(input logic [15:0] pkt, input logic [5:0] wrd,
                                        input logic [5:0] len);
        word_t w;
        w.pkt  = PW'(pkt);
        w.wrd  = wrd;
        w.tail = (wrd == len - 6'd1);
        w.head = (wrd == 6'd0);
        return w;
    endfunction

    // ack is asynchronous to clk; only the last stage is ever compared against req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
        end
    end

    assign ack_s       = ack_sync_q[SYNC_STAGES-1];
    assign xfer_done   = (ack_s == req_q);
    assign is_tail     = (word_idx_q == len_q - 6'd1);
    assign is_last_pkt = (pkt_idx_q == num_q - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            data_q      <= '0;
            pkt_tx_q    <= '0;
            fin_q       <= 1'b0;
            to_err_q    <= 1'b0;
            num_q       <= '0;
            len_q       <= 6'd1;
            pkt_idx_q   <= '0;
            word_idx_q  <= '0;
            setup_cnt_q <= '0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            data_q      <= data_d;
            pkt_tx_q    <= pkt_tx_d;
            fin_q       <= fin_d;
            to_err_q    <= to_err_d;
            num_q       <= num_d;
            len_q       <= len_d;
            pkt_idx_q   <= pkt_idx_d;
            word_idx_q  <= word_idx_d;
            setup_cnt_q <= setup_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        data_d      = data_q;
        pkt_tx_d    = pkt_tx_q;
        fin_d       = fin_q;
        to_err_d    = to_err_q;
        num_d       = num_q;
        len_d       = len_q;
        pkt_idx_d   = pkt_idx_q;
        word_idx_d  = word_idx_q;
        setup_cnt_d = setup_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d      = num_packets;
                    len_d      = (pkt_len == 6'd0) ? 6'd1 : pkt_len;
                    pkt_tx_d   = '0;
                    pkt_idx_d  = '0;
                    word_idx_d = '0;
                    if (num_packets == 16'd0) begin
                        state_d = DONE;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                        fin_d   = 1'b0;
                    end
                end
            end
            LOAD: begin
                setup_cnt_d = '0;
                state_d     = SETUP;
            end
            SETUP: begin
                if (setup_cnt_q == SW'(SETUP_CYCLES - 1)) begin
                    req_d    = ~req_q;
                    to_cnt_d = '0;
                    state_d  = WAIT_ACK;
                end else begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end
            end
            WAIT_ACK: begin
                if (to_cnt_q != TW'(TIMEOUT)) begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
                if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    to_err_d = 1'b1;
                end
                if (xfer_done) begin
                    if (!is_tail) begin
                        word_idx_d = word_idx_q + 6'd1;
                        state_d    = LOAD;
                    end else begin
                        pkt_tx_d = pkt_tx_q + 16'd1;
                        if (is_last_pkt) begin
                            state_d = DONE;
                            fin_d   = 1'b1;
                        end else begin
                            pkt_idx_d  = pkt_idx_q + 16'd1;
                            word_idx_d = '0;
                            gap_cnt_d  = '0;
                            state_d    = (GAP_CYCLES == 0) ? LOAD : GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Data changes only on entry to LOAD, so it leads the req edge by SETUP_CYCLES+1 cycles.
        if (state_d == LOAD) begin
            data_d = make_word(pkt_idx_d, word_idx_d, len_d);
        end
    end

    assign req         = req_q;
    assign Data        = data_q;
    assign PacketTX    = pkt_tx_q;
    assign Finished    = fin_q;
    assign timeout_err = to_err_q;
    assign busy        = (state_q == LOAD) || (state_q == SETUP) ||
                         (state_q == WAIT_ACK) || (state_q == GAP);

endmodule
